slt_serial: RTL and testbench
=============================

Name: slt_serial

Overview:
- Bit-serial, multi-cycle signed less-than comparator: the area-minimal, time-multiplexed counterpart of the parallel single-cycle comparator.
- Accepts two N-bit two's-complement operands through a valid/ready handshake.
- Subtracts them LSB-first, one bit per clock, through a 1-bit adder cell with a carry flop.
- Returns a 1-bit result (a < b) through a valid/ready handshake.
- Used by the multi-cycle ALU datapath where one full N-bit adder per comparator is too costly.

Parameters:
- N, 32, operand width in bits; legal values N >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  N  signed operand, sampled on input handshake.
- b  input  N  signed operand, sampled on input handshake.
- out_valid  output  1  out holds a completed result.
- out_ready  input  1  consumer accepts result this cycle.
- out  output  1  1 when a < b (signed), else 0.
- busy  output  1  high in SHIFT or DONE state.

Behaviour:
- Reset (sync, active-high, overrides everything incl. mid-operation):
  - state=IDLE; in_ready=1, out_valid=0, out=0, busy=0.
  - Shift registers, carry flop and bit counter cleared.
  - Any in-flight operation is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready:
    - load a_sr<=a, b_sr<=~b, carry<=1, cnt<=0;
    - capture sign bits sa<=a[N-1], sb<=b[N-1];
    - go to SHIFT.
  - Operand changes while in_valid=0 are ignored.
- SHIFT:
  - in_ready=0.
  - Each cycle:
    - d = a_sr[0]^b_sr[0]^carry;
    - carry <= majority(a_sr[0], b_sr[0], carry);
    - a_sr, b_sr shift right by 1;
    - cnt <= cnt+1.
  - On the cycle processing bit N-1 (cnt==N-1), d is the difference MSB.
  - In that cycle, register the result and go to DONE:
    - out = (sa != sb) ? sa : d.
  - No overflow handling is needed: operands of differing sign never reach the difference path.
- DONE:
  - out_valid=1; out held stable; in_ready=0.
  - On out_ready: go to IDLE next cycle (out_valid=0, out keeps last value).
  - out_ready low holds DONE indefinitely (backpressure); no result is lost.
- Latency and throughput:
  - Input handshake at edge k; out_valid first high in the cycle following edge k+N.
  - Exactly N cycles in SHIFT.
  - Minimum throughput: one result per N+2 cycles.
  - No acceptance in DONE, even if out_ready is high the same cycle.
- Counter width: $clog2(N)+1 bits; no wrap within an operation.
- a==b gives out=0; N=2 must work: 2 SHIFT cycles.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro SLT_SERIAL_UNSIGNED_EN.
- Defined:
  - Adds port "is_unsigned input 1", sampled with the operands on the input handshake.
  - When captured is_unsigned=1: out = ~carry_final, where carry_final is the carry out of bit N-1 (borrow means a < b unsigned).
  - Sign capture is ignored in that mode.
  - Latency unchanged.
- Not defined: port absent; all comparisons signed; no extra flops.

Test Plan:
- N=32, a=5, b=7, out_ready=1 -> out_valid exactly 32 cycles after accept, out=1; IDLE next cycle.
- a=0xFFFFFFFF (-1), b=1 -> out=1. Swap operands -> out=0.
- a=0x7FFFFFFF, b=0x80000000 -> out=0. a=0x80000000, b=0x7FFFFFFF -> out=1 (overflow-prone cases).
- a=b=0xFFFFFFFD -> out=0. a=0, b=0 -> out=0.
- Backpressure: a=3, b=9, out_ready low 5 cycles after out_valid -> out=1 held stable, in_ready=0, in_valid pulses ignored. Then raise out_ready -> one result consumed; next operands accepted.
- Reset in 10th SHIFT cycle -> next cycle in_ready=1, out_valid=0, busy=0. New op a=-8, b=-2 -> out=1 after 32 cycles.
- With SLT_SERIAL_UNSIGNED_EN: a=0xFFFFFFFF, b=1, is_unsigned=1 -> out=0. Same operands with is_unsigned=0 -> out=1.

Source files
------------

// File: rtl/slt_serial.sv
// Bit-serial signed less-than comparator: subtracts LSB-first through a 1-bit adder cell, N cycles per compare.
// Optional macro SLT_SERIAL_UNSIGNED_EN adds an is_unsigned input selecting an unsigned compare.
module slt_serial #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
`ifdef SLT_SERIAL_UNSIGNED_EN
   input  logic         is_unsigned,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out,
   output logic         busy
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   a_sr_q, a_sr_d;
   logic [N-1:0]   b_sr_q, b_sr_d;
   logic           carry_q, carry_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sa_q, sa_d;
   logic           sb_q, sb_d;
   logic           out_q, out_d;
`ifdef SLT_SERIAL_UNSIGNED_EN
   logic           uns_q, uns_d;
`endif

   logic           diff_bit;
   logic           carry_nxt;
   logic           last_bit;
   logic           result;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   // a - b computed as a + ~b + 1; the carry flop starts at 1 to supply the +1
   assign diff_bit  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
   assign carry_nxt = maj3(a_sr_q[0], b_sr_q[0], carry_q);
   assign last_bit  = (cnt_q == CW'(N - 1));

`ifdef SLT_SERIAL_UNSIGNED_EN
   // No carry out of the MSB means a borrow, i.e. a < b unsigned
   assign result = uns_q ? ~carry_nxt : ((sa_q != sb_q) ? sa_q : diff_bit);
`else
   assign result = (sa_q != sb_q) ? sa_q : diff_bit;
`endif

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      out_d   = out_q;
`ifdef SLT_SERIAL_UNSIGNED_EN
      uns_d   = uns_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sr_d  = a;
               b_sr_d  = ~b;
               carry_d = 1'b1;
               cnt_d   = '0;
               sa_d    = a[N-1];
               sb_d    = b[N-1];
`ifdef SLT_SERIAL_UNSIGNED_EN
               uns_d   = is_unsigned;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = carry_nxt;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               out_d   = result;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         out_q   <= 1'b0;
`ifdef SLT_SERIAL_UNSIGNED_EN
         uns_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         out_q   <= out_d;
`ifdef SLT_SERIAL_UNSIGNED_EN
         uns_q   <= uns_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == SHIFT) || (state_q == DONE);
   assign out       = out_q;

endmodule

// File: tb/tb_slt_serial.sv
// Self-checking bench for slt_serial: directed and random compares against an arithmetic reference model.
module tb_slt_serial;

   localparam int N = 32;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
`ifdef SLT_SERIAL_UNSIGNED_EN
   logic         is_unsigned;
`endif
   logic         out_valid;
   logic         out_ready;
   logic         out;
   logic         busy;

   int n_assert = 0;
   int n_fail   = 0;

   slt_serial #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
`ifdef SLT_SERIAL_UNSIGNED_EN
      .is_unsigned(is_unsigned),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: signed compare via sign-extended integers, unsigned via zero-extended
   function automatic logic model(input logic [N-1:0] x, input logic [N-1:0] y, input logic uns);
      longint sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (uns) return ({32'd0, x} < {32'd0, y});
      return (sx < sy);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                        input logic uns, input int stall);
      logic exp;
      int   cyc;
      logic eff_uns;
`ifdef SLT_SERIAL_UNSIGNED_EN
      eff_uns = uns;
`else
      eff_uns = 1'b0;
`endif
      exp = model(ta, tb_v, eff_uns);
      chk({tag, "_in_ready_idle"}, in_ready, 1'b1);
      a        = ta;
      b        = tb_v;
`ifdef SLT_SERIAL_UNSIGNED_EN
      is_unsigned = uns;
`endif
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      tick();
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      chk({tag, "_busy_shift"}, {in_ready, busy, out_valid}, 3'b010);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < N + 20) begin
         tick();
         cyc++;
      end
      chk({tag, "_latency"}, cyc, N);
      chk({tag, "_out"}, out, exp);
      chk({tag, "_done_flags"}, {in_ready, busy}, 2'b01);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         a        = $urandom;
         b        = $urandom;
         tick();
         chk({tag, "_stall_hold"}, {out_valid, in_ready, out}, {2'b10, exp});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (stall != 0) tick();
      else begin
         tick();
      end
      chk({tag, "_back_idle"}, {in_ready, out_valid, busy, out}, {3'b100, exp});
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
`ifdef SLT_SERIAL_UNSIGNED_EN
      is_unsigned = 1'b0;
`endif
      tick();
      tick();
      chk("reset_state", {in_ready, out_valid, out, busy}, 4'b1000);
      rst = 1'b0;
      tick();

      // ignored operands while in_valid is low
      a = 32'd1;
      b = 32'd2;
      tick();
      chk("idle_no_accept", {in_ready, busy}, 2'b10);

      do_op("p5_7",      32'd5,          32'd7,          1'b0, 0);
      do_op("m1_1",      32'hFFFF_FFFF,  32'd1,          1'b0, 0);
      do_op("1_m1",      32'd1,          32'hFFFF_FFFF,  1'b0, 0);
      do_op("max_min",   32'h7FFF_FFFF,  32'h8000_0000,  1'b0, 0);
      do_op("min_max",   32'h8000_0000,  32'h7FFF_FFFF,  1'b0, 0);
      do_op("eq_neg",    32'hFFFF_FFFD,  32'hFFFF_FFFD,  1'b0, 0);
      do_op("eq_zero",   32'd0,          32'd0,          1'b0, 0);
      do_op("bp_3_9",    32'd3,          32'd9,          1'b0, 5);
      do_op("after_bp",  32'd9,          32'd3,          1'b0, 0);

      // reset during the 10th SHIFT cycle
      a        = 32'd100;
      b        = 32'd200;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_reset", {in_ready, out_valid, busy, out}, 4'b1000);
      tick();
      chk("mid_reset_stay", {in_ready, out_valid, busy}, 3'b100);
      do_op("m8_m2", -32'sd8, -32'sd2, 1'b0, 0);

`ifdef SLT_SERIAL_UNSIGNED_EN
      do_op("uns_m1_1",  32'hFFFF_FFFF, 32'd1, 1'b1, 0);
      do_op("sgn_m1_1",  32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      do_op("uns_eq",    32'h8000_0000, 32'h8000_0000, 1'b1, 0);
      do_op("uns_1_max", 32'd1, 32'hFFFF_FFFF, 1'b1, 0);
`endif

      for (int i = 0; i < 24; i++) begin
         logic [N-1:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (i % 6 == 0) rb = ra;
         if (i % 6 == 1) rb = ra ^ 32'h8000_0000;
         do_op("rand", ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
